// File: rtl/bp_tlb_ptw_pkg.sv
// bp_tlb_ptw_pkg: Sv39 page-table constants, PTE layout and TLB leaf entry for the walker
package bp_tlb_ptw_pkg;

    localparam int vtag_width_p           = 27;
    localparam int paddr_width_p          = 56;
    localparam int ptag_width_lp          = paddr_width_p - 12;

    localparam int sv39_levels_gp         = 3;
    localparam int sv39_page_idx_width_gp = 9;
    localparam int sv39_pte_width_gp      = 64;
    localparam int sv39_ppn_width_gp      = 44;

    localparam int sv39_v_bit_gp = 0;
    localparam int sv39_r_bit_gp = 1;
    localparam int sv39_w_bit_gp = 2;
    localparam int sv39_x_bit_gp = 3;
    localparam int sv39_u_bit_gp = 4;
    localparam int sv39_a_bit_gp = 6;
    localparam int sv39_d_bit_gp = 7;

    typedef struct packed {
        logic [9:0]                   reserved;
        logic [sv39_ppn_width_gp-1:0] ppn;
        logic [1:0]                   rsw;
        logic                         d;
        logic                         a;
        logic                         g;
        logic                         u;
        logic                         x;
        logic                         w;
        logic                         r;
        logic                         v;
    } sv39_pte_s;

    typedef struct packed {
        logic [ptag_width_lp-1:0] ptag;
        logic                     u;
        logic                     x;
        logic                     w;
        logic                     r;
        logic                     a;
        logic                     d;
    } bp_pte_entry_leaf_s;

    localparam int entry_width_lp = $bits(bp_pte_entry_leaf_s);

endpackage

// File: rtl/bp_tlb_ptw_if.sv
// bp_tlb_ptw_if: PTE read bus between the walker (master) and memory (slave)
interface bp_tlb_ptw_if;
    import bp_tlb_ptw_pkg::*;

    logic                          mem_req_v;
    logic [paddr_width_p-1:0]      mem_req_paddr;
    logic                          mem_req_ready;
    logic                          mem_resp_v;
    logic [sv39_pte_width_gp-1:0]  mem_resp_data;

    modport master (
        output mem_req_v, mem_req_paddr,
        input  mem_req_ready, mem_resp_v, mem_resp_data
    );

    modport slave (
        input  mem_req_v, mem_req_paddr,
        output mem_req_ready, mem_resp_v, mem_resp_data
    );

endinterface

// File: rtl/bp_tlb_ptw_pte_decode.sv
// bp_tlb_ptw_pte_decode: classifies a fetched Sv39 PTE as leaf, pointer or fault
module bp_tlb_ptw_pte_decode
    import bp_tlb_ptw_pkg::*;
(
    input  logic [sv39_pte_width_gp-1:0] pte_i,
    input  logic [1:0]                   level_i,
    output logic                         leaf_o,
    output logic                         fault_o,
    output logic [sv39_ppn_width_gp-1:0] next_ppn_o
);

    sv39_pte_s pte;
    logic      misaligned;
    logic      unused;

    assign pte    = sv39_pte_s'(pte_i);
    assign unused = ^{pte.reserved, pte.rsw, pte.g, pte.u, pte.d};

    // superpage leaves must have their low PPN bits clear; any violation is a fault
    always_comb begin
        leaf_o     = pte.r | pte.x;
        next_ppn_o = pte.ppn;
        misaligned = (level_i == 2'd1 && pte.ppn[8:0] != '0) || (level_i == 2'd2 && pte.ppn[17:0] != '0);
        fault_o    = !pte.v | (!pte.r & pte.w) | (leaf_o & !pte.a) | (!leaf_o & level_i == 2'd0) | (leaf_o & misaligned);
    end

endmodule

// File: rtl/bp_tlb_ptw.sv
// bp_tlb_ptw: Sv39 page-table walker filling a TLB with 4 KiB-splintered leaves
module bp_tlb_ptw
    import bp_tlb_ptw_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic [sv39_ppn_width_gp-1:0] satp_ppn_i,
    input  logic                         miss_v_i,
    input  logic [vtag_width_p-1:0]      miss_vtag_i,
    output logic                         miss_ready_o,
    output logic                         busy_o,
    bp_tlb_ptw_if.master                 mem,
    output logic                         tlb_w_v_o,
    output logic [vtag_width_p-1:0]      tlb_w_vtag_o,
    output logic [entry_width_lp-1:0]    tlb_w_entry_o,
    output logic                         fault_v_o,
    output logic [vtag_width_p-1:0]      fault_vtag_o
);

    typedef enum logic [2:0] {E_IDLE, E_REQ, E_RESP, E_FILL, E_FAULT, E_DRAIN} state_e;

    state_e                       state_q, state_d;
    logic [vtag_width_p-1:0]      vtag_q, vtag_d;
    logic [1:0]                   level_q, level_d;
    logic [sv39_ppn_width_gp-1:0] ppn_q, ppn_d;
    logic [5:0]                   perm_q, perm_d;
    logic                         leaf, fault;
    logic [sv39_ppn_width_gp-1:0] next_ppn;
    logic [8:0]                   vpn;
    logic [ptag_width_lp-1:0]     mask;
    bp_pte_entry_leaf_s           entry;

    bp_tlb_ptw_pte_decode decode (
        .pte_i      (mem.mem_resp_data),
        .level_i    (level_q),
        .leaf_o     (leaf),
        .fault_o    (fault),
        .next_ppn_o (next_ppn)
    );

    // walk state and captured translation context
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= E_IDLE;
            vtag_q  <= '0;
            level_q <= '0;
            ppn_q   <= '0;
            perm_q  <= '0;
        end else begin
            state_q <= state_d;
            vtag_q  <= vtag_d;
            level_q <= level_d;
            ppn_q   <= ppn_d;
            perm_q  <= perm_d;
        end
    end

    // next-state: a flush after the request handshake leaves one response to drain
    always_comb begin
        state_d = state_q;
        vtag_d  = vtag_q;
        level_d = level_q;
        ppn_d   = ppn_q;
        perm_d  = perm_q;
        unique case (state_q)
            E_IDLE: if (miss_v_i && !flush_i) begin
                vtag_d  = miss_vtag_i;
                level_d = 2'(sv39_levels_gp - 1);
                ppn_d   = satp_ppn_i;
                state_d = E_REQ;
            end
            E_REQ: if (flush_i) state_d = mem.mem_req_ready ? E_DRAIN : E_IDLE;
                   else if (mem.mem_req_ready) state_d = E_RESP;
            E_RESP: if (flush_i) state_d = mem.mem_resp_v ? E_IDLE : E_DRAIN;
                    else if (mem.mem_resp_v) begin
                        ppn_d   = next_ppn;
                        perm_d  = {mem.mem_resp_data[sv39_u_bit_gp], mem.mem_resp_data[sv39_x_bit_gp],
                                   mem.mem_resp_data[sv39_w_bit_gp], mem.mem_resp_data[sv39_r_bit_gp],
                                   mem.mem_resp_data[sv39_a_bit_gp], mem.mem_resp_data[sv39_d_bit_gp]};
                        level_d = (fault || leaf) ? level_q : level_q - 2'd1;
                        state_d = fault ? E_FAULT : leaf ? E_FILL : E_REQ;
                    end
            E_FILL, E_FAULT: state_d = E_IDLE;
            E_DRAIN: if (mem.mem_resp_v) state_d = E_IDLE;
            default: state_d = E_IDLE;
        endcase
    end

    // low 9*level ptag bits come from the vtag so superpages land as 4 KiB entries
    always_comb begin
        vpn   = vtag_q[sv39_page_idx_width_gp*level_q +: sv39_page_idx_width_gp];
        mask  = (ptag_width_lp'(1) << (sv39_page_idx_width_gp * level_q)) - ptag_width_lp'(1);
        entry = {(ppn_q & ~mask) | (ptag_width_lp'(vtag_q) & mask), perm_q};
    end

    assign miss_ready_o      = state_q == E_IDLE && !flush_i;
    assign busy_o            = state_q != E_IDLE;
    assign mem.mem_req_v     = state_q == E_REQ;
    assign mem.mem_req_paddr = paddr_width_p'({ppn_q, vpn, 3'b000});
    assign tlb_w_v_o         = state_q == E_FILL && !flush_i;
    assign tlb_w_vtag_o      = vtag_q;
    assign tlb_w_entry_o     = entry;
    assign fault_v_o         = state_q == E_FAULT && !flush_i;
    assign fault_vtag_o      = vtag_q;

endmodule

// File: tb/tb_bp_tlb_ptw.sv
// tb_bp_tlb_ptw: directed Sv39 walks, faults, flush, backpressure and busy checks
module tb_bp_tlb_ptw;
    import bp_tlb_ptw_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset, flush, miss_v;
    logic [43:0]               satp;
    logic [26:0]               miss_vtag;
    logic                      miss_ready, busy, tlb_w_v, fault_v;
    logic [26:0]               tlb_w_vtag, fault_vtag;
    logic [entry_width_lp-1:0] tlb_w_entry;
    bp_pte_entry_leaf_s        ent;

    int n_vec = 0, n_err = 0, fills = 0, faults = 0, reqs = 0, cyc = 0;
    int r0, f0, x0, t0;

    bp_tlb_ptw_if mem_if ();

    bp_tlb_ptw dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .flush_i       (flush),
        .satp_ppn_i    (satp),
        .miss_v_i      (miss_v),
        .miss_vtag_i   (miss_vtag),
        .miss_ready_o  (miss_ready),
        .busy_o        (busy),
        .mem           (mem_if),
        .tlb_w_v_o     (tlb_w_v),
        .tlb_w_vtag_o  (tlb_w_vtag),
        .tlb_w_entry_o (tlb_w_entry),
        .fault_v_o     (fault_v),
        .fault_vtag_o  (fault_vtag)
    );

    assign ent = bp_pte_entry_leaf_s'(tlb_w_entry);

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tlb_w_v) fills++;
        if (fault_v) faults++;
        if (mem_if.mem_req_v && mem_if.mem_req_ready) reqs++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [26:0] vt);
        miss_vtag = vt;
        miss_v    = 1'b1;
        check("miss_ready", 64'(miss_ready), 64'd1);
        tick();
        miss_v = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [55:0] addr, input logic [63:0] pte);
        int i = 0;
        while (!mem_if.mem_req_v && i < 20) begin
            tick();
            i++;
        end
        check({tag, "_reqv"}, 64'(mem_if.mem_req_v), 64'd1);
        check({tag, "_paddr"}, 64'(mem_if.mem_req_paddr), 64'(addr));
        mem_if.mem_req_ready = 1'b1;
        tick();
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_resp_v    = 1'b1;
        mem_if.mem_resp_data = pte;
        tick();
        mem_if.mem_resp_v    = 1'b0;
    endtask

    // perm is {u, x, w, r, a, d}
    task automatic expect_fill(input string tag, input logic [26:0] vt, input logic [43:0] ptag, input logic [5:0] perm);
        check({tag, "_wv"}, 64'(tlb_w_v), 64'd1);
        check({tag, "_wvtag"}, 64'(tlb_w_vtag), 64'(vt));
        check({tag, "_ptag"}, 64'(ent.ptag), 64'(ptag));
        check({tag, "_perm"}, 64'({ent.u, ent.x, ent.w, ent.r, ent.a, ent.d}), 64'(perm));
        check({tag, "_nofault"}, 64'(fault_v), 64'd0);
        tick();
        check({tag, "_wv_off"}, 64'(tlb_w_v), 64'd0);
        check({tag, "_idle"}, 64'(miss_ready), 64'd1);
    endtask

    task automatic expect_fault(input string tag, input logic [26:0] vt);
        check({tag, "_fv"}, 64'(fault_v), 64'd1);
        check({tag, "_fvtag"}, 64'(fault_vtag), 64'(vt));
        check({tag, "_nofill"}, 64'(tlb_w_v), 64'd0);
        tick();
        check({tag, "_fv_off"}, 64'(fault_v), 64'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; miss_v = 1'b0; miss_vtag = '0; satp = 44'h80000;
        mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_v = 1'b0; mem_if.mem_resp_data = '0;
        tick(); tick();
        check("rst_ready", 64'(miss_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_reqv", 64'(mem_if.mem_req_v), 64'd0);
        check("rst_wv", 64'(tlb_w_v), 64'd0);
        check("rst_fv", 64'(fault_v), 64'd0);
        check("rst_paddr", 64'(mem_if.mem_req_paddr), 64'd0);
        reset = 1'b0;
        tick();

        // zero-wait 4 KiB walk, fill at cycle 7
        r0 = reqs; f0 = fills; t0 = cyc;
        start(27'h0040201);
        check("w4k_busy", 64'(busy), 64'd1);
        serve("w4k_l2", 56'h80000008, 64'h20000401);
        serve("w4k_l1", 56'h80001008, 64'h20000801);
        serve("w4k_l0", 56'h80002008, 64'h2048D0C7);
        check("w4k_lat", 64'(cyc - t0), 64'd7);
        expect_fill("w4k", 27'h0040201, 44'h81234, 6'b001111);
        check("w4k_reqs", 64'(reqs - r0), 64'd3);
        check("w4k_fills", 64'(fills - f0), 64'd1);

        // megapage leaf at level 1
        r0 = reqs;
        start(27'h0040201);
        serve("mega_l2", 56'h80000008, 64'h20000401);
        serve("mega_l1", 56'h80001008, 64'h200800CB);
        expect_fill("mega", 27'h0040201, 44'h80201, 6'b010111);
        check("mega_reqs", 64'(reqs - r0), 64'd2);

        // fault cases
        f0 = fills; x0 = faults;
        start(27'h0C40201);
        serve("finv", 56'h80000188, 64'h0);
        expect_fault("finv", 27'h0C40201);
        start(27'h0040201);
        serve("fnoa", 56'h80000008, 64'h20080087);
        expect_fault("fnoa", 27'h0040201);
        start(27'h0040201);
        serve("fl0_l2", 56'h80000008, 64'h20000401);
        serve("fl0_l1", 56'h80001008, 64'h20000801);
        serve("fl0_l0", 56'h80002008, 64'h20000C01);
        expect_fault("fl0", 27'h0040201);
        start(27'h0040201);
        serve("fmis_l2", 56'h80000008, 64'h20000401);
        serve("fmis_l1", 56'h80001008, 64'h200804CB);
        expect_fault("fmis", 27'h0040201);
        start(27'h0C40201);
        serve("fwnr", 56'h80000188, 64'h20000405);
        expect_fault("fwnr", 27'h0C40201);
        check("flt_count", 64'(faults - x0), 64'd5);
        check("flt_nofill", 64'(fills - f0), 64'd0);

        // flush during E_RESP, stale response three cycles later
        f0 = fills; x0 = faults;
        start(27'h0040201);
        check("fl_reqv", 64'(mem_if.mem_req_v), 64'd1);
        mem_if.mem_req_ready = 1'b1;
        tick();
        mem_if.mem_req_ready = 1'b0;
        flush = 1'b1;
        check("fl_blocked", 64'(miss_ready), 64'd0);
        tick();
        flush = 1'b0;
        check("fl_drain_busy", 64'(busy), 64'd1);
        check("fl_drain_noreq", 64'(mem_if.mem_req_v), 64'd0);
        tick();
        tick();
        check("fl_drain_busy2", 64'(busy), 64'd1);
        mem_if.mem_resp_v = 1'b1;
        mem_if.mem_resp_data = 64'h2048D0C7;
        tick();
        mem_if.mem_resp_v = 1'b0;
        check("fl_idle", 64'(busy), 64'd0);
        check("fl_nofill", 64'(fills - f0), 64'd0);
        check("fl_nofault", 64'(faults - x0), 64'd0);
        start(27'h0040201);
        serve("flw_l2", 56'h80000008, 64'h20000401);
        serve("flw_l1", 56'h80001008, 64'h20000801);
        serve("flw_l0", 56'h80002008, 64'h2048D0C7);
        expect_fill("flw", 27'h0040201, 44'h81234, 6'b001111);

        // request backpressure for five cycles
        r0 = reqs;
        start(27'h0040201);
        for (int i = 0; i < 5; i++) begin
            check("bp_reqv", 64'(mem_if.mem_req_v), 64'd1);
            check("bp_paddr", 64'(mem_if.mem_req_paddr), 64'h80000008);
            tick();
        end
        serve("bp_l2", 56'h80000008, 64'h20000401);
        serve("bp_l1", 56'h80001008, 64'h20000801);
        serve("bp_l0", 56'h80002008, 64'h2048D0C7);
        expect_fill("bp", 27'h0040201, 44'h81234, 6'b001111);
        check("bp_reqs", 64'(reqs - r0), 64'd3);

        // miss held through a walk, then accepted as a gigapage walk
        start(27'h0040201);
        miss_vtag = 27'h0C40201;
        miss_v    = 1'b1;
        check("busy_nrdy0", 64'(miss_ready), 64'd0);
        serve("busy_l2", 56'h80000008, 64'h20000401);
        check("busy_nrdy1", 64'(miss_ready), 64'd0);
        serve("busy_l1", 56'h80001008, 64'h20000801);
        serve("busy_l0", 56'h80002008, 64'h2048D0C7);
        check("busy_nrdy_fill", 64'(miss_ready), 64'd0);
        expect_fill("busy", 27'h0040201, 44'h81234, 6'b001111);
        tick();
        miss_v = 1'b0;
        check("busy_accepted", 64'(busy), 64'd1);
        serve("giga_l2", 56'h80000188, 64'h200000CF);
        expect_fill("giga", 27'h0C40201, 44'h80201, 6'b011111);

        // reset mid-walk
        start(27'h0040201);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmid_busy", 64'(busy), 64'd0);
        check("rmid_reqv", 64'(mem_if.mem_req_v), 64'd0);
        check("rmid_ready", 64'(miss_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
